lcd1602_bus_receiver: RTL and testbench

LCD1602_BUS_RECEIVER -- requirements
Module: lcd1602_bus_receiver

---
 rtl/lcd1602_bus_receiver.sv | 252 +++++++++++++++++++++++++
 tb/tb_lcd1602_bus_receiver.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd1602_bus_receiver.sv
// LCD1602 (HD44780-style) bus receiver: DDRAM shadow, cursor and mode tracking.
// Optional bus read-back is built in when LCD_RX_READ_EN is defined.
module lcd1602_bus_receiver #(
    parameter logic [7:0] CLEAR_CHAR  = 8'h20,
    parameter int         MIN_EN_HIGH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rs,
    input  logic       rw,
    input  logic       enable,
    input  logic [7:0] data,
    output logic [7:0] data_out,
    output logic       data_oe,
    input  logic [6:0] ddr_rd_addr,
    output logic [7:0] ddr_rd_data,
    output logic [6:0] cursor_idx,
    output logic       busy,
    output logic       cmd_strobe,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       inc_mode,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, EXEC, CLEAR} state_t;

    localparam logic [3:0] MIN_HI = 4'(MIN_EN_HIGH);

    logic       r_rs_m, r_rs_s, r_rw_m, r_rw_s, r_en_m, r_en_s;
    logic [7:0] r_dat_m, r_dat_s;
    logic [3:0] r_hi_cnt;
    state_t     r_state;
    logic [6:0] r_addr;
    logic [6:0] r_fill;
    logic       r_clr, r_inc, r_disp, r_cur, r_blink, r_busy, r_strobe, r_err;
    logic [7:0] r_mem [0:79];
    logic [7:0] r_rd_data;

    logic       w_xfer, w_act, w_wr, w_we;
    logic [6:0] w_cur_idx, w_waddr;
    logic [7:0] w_wdata;

    function automatic logic [6:0] f_idx(input logic [6:0] a);
        return (a < 7'h40) ? a : a - 7'h18;
    endfunction

    // DDRAM addresses skip the 0x28-0x3F and 0x68-0x7F holes
    function automatic logic [6:0] f_step(input logic [6:0] a, input logic up);
        if (up)
            return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
        else
            return (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
    endfunction

    function automatic logic f_valid(input logic [6:0] a);
        return (a <= 7'h27) || (a >= 7'h40 && a <= 7'h67);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rs_m  <= 1'b0;
            r_rs_s  <= 1'b0;
            r_rw_m  <= 1'b0;
            r_rw_s  <= 1'b0;
            r_en_m  <= 1'b0;
            r_en_s  <= 1'b0;
            r_dat_m <= 8'h00;
            r_dat_s <= 8'h00;
            r_hi_cnt <= 4'd0;
        end else begin
            r_rs_m  <= rs;
            r_rs_s  <= r_rs_m;
            r_rw_m  <= rw;
            r_rw_s  <= r_rw_m;
            r_en_m  <= enable;
            r_en_s  <= r_en_m;
            r_dat_m <= data;
            r_dat_s <= r_dat_m;
            if (r_en_s)
                r_hi_cnt <= (r_hi_cnt == 4'hF) ? r_hi_cnt : r_hi_cnt + 4'd1;
            else
                r_hi_cnt <= 4'd0;
        end
    end

    assign w_xfer    = ~r_en_s && (r_hi_cnt >= MIN_HI);
    assign w_cur_idx = f_idx(r_addr);

`ifdef LCD_RX_READ_EN
    // Status reads are answered on the bus and never count as dropped transfers
    assign w_act = w_xfer && !(r_rw_s && !r_rs_s);
`else
    assign w_act = w_xfer && !r_rw_s;
`endif
    assign w_wr = w_act && (r_state == IDLE) && r_rs_s && !r_rw_s;

    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_fill;
        w_wdata = CLEAR_CHAR;
        if (r_state == CLEAR) begin
            w_we = 1'b1;
        end else if (w_wr) begin
            w_we    = 1'b1;
            w_waddr = w_cur_idx;
            w_wdata = r_dat_s;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[w_waddr] <= w_wdata;
    end

    always_ff @(posedge clk) begin
        r_rd_data <= (ddr_rd_addr < 7'd80) ? r_mem[ddr_rd_addr] : 8'h00;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_addr   <= 7'h00;
            r_fill   <= 7'd0;
            r_clr    <= 1'b0;
            r_inc    <= 1'b1;
            r_disp   <= 1'b0;
            r_cur    <= 1'b0;
            r_blink  <= 1'b0;
            r_busy   <= 1'b0;
            r_strobe <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_act) begin
                        if (r_rs_s) begin
                            r_addr   <= f_step(r_addr, r_inc);
                            r_state  <= EXEC;
                            r_busy   <= 1'b1;
                            r_strobe <= 1'b1;
                        end else begin
                            priority case (1'b1)
                                r_dat_s[7]: begin
                                    if (f_valid(r_dat_s[6:0])) begin
                                        r_addr   <= r_dat_s[6:0];
                                        r_state  <= EXEC;
                                        r_busy   <= 1'b1;
                                        r_strobe <= 1'b1;
                                    end else begin
                                        r_err <= 1'b1;
                                    end
                                end
                                r_dat_s[6]: r_err <= 1'b1;
                                r_dat_s[5]: begin
                                    r_state  <= EXEC;
                                    r_busy   <= 1'b1;
                                    r_strobe <= 1'b1;
                                end
                                r_dat_s[4]: begin
                                    if (!r_dat_s[3])
                                        r_addr <= f_step(r_addr, r_dat_s[2]);
                                    r_state  <= EXEC;
                                    r_busy   <= 1'b1;
                                    r_strobe <= 1'b1;
                                end
                                r_dat_s[3]: begin
                                    r_disp   <= r_dat_s[2];
                                    r_cur    <= r_dat_s[1];
                                    r_blink  <= r_dat_s[0];
                                    r_state  <= EXEC;
                                    r_busy   <= 1'b1;
                                    r_strobe <= 1'b1;
                                end
                                r_dat_s[2]: begin
                                    r_inc    <= r_dat_s[1];
                                    r_state  <= EXEC;
                                    r_busy   <= 1'b1;
                                    r_strobe <= 1'b1;
                                end
                                r_dat_s[1]: begin
                                    r_addr   <= 7'h00;
                                    r_state  <= EXEC;
                                    r_busy   <= 1'b1;
                                    r_strobe <= 1'b1;
                                end
                                r_dat_s[0]: begin
                                    r_addr   <= 7'h00;
                                    r_inc    <= 1'b1;
                                    r_clr    <= 1'b1;
                                    r_fill   <= 7'd0;
                                    r_state  <= EXEC;
                                    r_busy   <= 1'b1;
                                    r_strobe <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                EXEC: begin
                    r_state <= r_clr ? CLEAR : IDLE;
                    r_busy  <= r_clr;
                    r_clr   <= 1'b0;
                end
                CLEAR: begin
                    r_fill <= r_fill + 7'd1;
                    if (r_fill == 7'd79) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
            if (w_act && r_state != IDLE)
                r_err <= 1'b1;
        end
    end

`ifdef LCD_RX_READ_EN
    logic [7:0] r_dout;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_dout <= 8'h00;
        else if (r_en_s && r_rw_s)
            r_dout <= r_rs_s ? r_mem[w_cur_idx] : {r_busy, r_addr};
    end

    assign data_out = r_dout;
    assign data_oe  = r_en_s && r_rw_s;
`else
    assign data_out = 8'h00;
    assign data_oe  = 1'b0;
`endif

    assign ddr_rd_data = r_rd_data;
    assign cursor_idx  = w_cur_idx;
    assign busy        = r_busy;
    assign cmd_strobe  = r_strobe;
    assign disp_on     = r_disp;
    assign cursor_on   = r_cur;
    assign blink_on    = r_blink;
    assign inc_mode    = r_inc;
    assign err         = r_err;

endmodule

// File: tb/tb_lcd1602_bus_receiver.sv
// Randomized bench for lcd1602_bus_receiver against a linear-index reference model.
// Covers directed display scenarios plus random command/data traffic.
module tb_lcd1602_bus_receiver;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rs = 1'b0, rw = 1'b0, enable = 1'b0;
    logic [7:0] data = 8'h00;
    logic [7:0] data_out;
    logic       data_oe;
    logic [6:0] ddr_rd_addr = 7'd0;
    logic [7:0] ddr_rd_data;
    logic [6:0] cursor_idx;
    logic       busy, cmd_strobe, disp_on, cursor_on, blink_on, inc_mode, err;

    lcd1602_bus_receiver dut (
        .clk(clk), .reset(reset), .rs(rs), .rw(rw), .enable(enable),
        .data(data), .data_out(data_out), .data_oe(data_oe),
        .ddr_rd_addr(ddr_rd_addr), .ddr_rd_data(ddr_rd_data),
        .cursor_idx(cursor_idx), .busy(busy), .cmd_strobe(cmd_strobe),
        .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .inc_mode(inc_mode), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int n_strobe = 0, n_busy = 0;

    always @(posedge clk) begin
        if (cmd_strobe === 1'b1) n_strobe++;
        if (busy === 1'b1) n_busy++;
    end

    // reference model: cursor kept as linear cell index 0..79
    logic [7:0] m_mem [80];
    int m_cur = 0;
    bit m_inc = 1, m_disp = 0, m_curon = 0, m_blink = 0, m_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic bus(input logic rs_i, input logic rw_i, input logic [7:0] d, input int hi);
        @(negedge clk);
        rs = rs_i; rw = rw_i; data = d;
        @(negedge clk);
        enable = 1'b1;
        repeat (hi) @(negedge clk);
        enable = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic model(input logic rs_i, input logic rw_i, input logic [7:0] d,
                         input int hi, output int st, output bit clr);
        int a;
        st = 0; clr = 0;
        if (hi < 2 || rw_i) return;
        if (rs_i) begin
            m_mem[m_cur] = d;
            m_cur = m_inc ? (m_cur + 1) % 80 : (m_cur + 79) % 80;
            st = 1;
            return;
        end
        a = d & 8'h7f;
        if (d == 0) st = 0;
        else if (d >= 8'h80) begin
            if (a < 8'h28) begin m_cur = a; st = 1; end
            else if (a >= 8'h40 && a < 8'h68) begin m_cur = a - 8'h18; st = 1; end
            else m_err = 1;
        end else if (d >= 8'h40) m_err = 1;
        else if (d >= 8'h20) st = 1;
        else if (d >= 8'h10) begin
            st = 1;
            if (!d[3]) m_cur = d[2] ? (m_cur + 1) % 80 : (m_cur + 79) % 80;
        end else if (d >= 8'h08) begin
            st = 1; m_disp = d[2]; m_curon = d[1]; m_blink = d[0];
        end else if (d >= 8'h04) begin
            st = 1; m_inc = d[1];
        end else if (d >= 8'h02) begin
            st = 1; m_cur = 0;
        end else begin
            st = 1; clr = 1; m_cur = 0; m_inc = 1;
            for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 300 && busy; k++) @(negedge clk);
        chk("idle_wait", busy, 1'b0);
    endtask

    task automatic xfer(input logic rs_i, input logic rw_i, input logic [7:0] d, input int hi);
        int s0, st;
        bit clr;
        s0 = n_strobe;
        model(rs_i, rw_i, d, hi, st, clr);
        bus(rs_i, rw_i, d, hi);
        if (clr) wait_idle();
        chk("cursor", cursor_idx, m_cur);
        chk("inc", inc_mode, m_inc);
        chk("disp", {disp_on, cursor_on, blink_on}, {m_disp, m_curon, m_blink});
        chk("err", err, m_err);
        chk("strobe", n_strobe - s0, st);
    endtask

    task automatic rd(input int idx, output logic [7:0] v);
        @(negedge clk);
        ddr_rd_addr = 7'(idx);
        @(negedge clk);
        v = ddr_rd_data;
    endtask

`ifdef LCD_RX_READ_EN
    task automatic rd_bus(input logic rs_i, output logic [7:0] v, output logic oe);
        @(negedge clk);
        rs = rs_i; rw = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        v = data_out; oe = data_oe;
        enable = 1'b0;
        repeat (5) @(negedge clk);
        rw = 1'b0;
    endtask
`endif

    initial begin
        logic [7:0] v, old79;
        logic oe;
        int k, s0;
        logic [7:0] d;

        repeat (3) @(negedge clk);
        chk("rst_cursor", cursor_idx, 7'd0);
        chk("rst_flags", {inc_mode, disp_on, cursor_on, blink_on}, 4'b1000);
        chk("rst_busy", {busy, cmd_strobe, err}, 3'b000);
        chk("rst_dout", {data_oe, data_out}, 9'h000);
        reset = 1'b1;

        xfer(0, 0, 8'h38, 2);
        xfer(0, 0, 8'h06, 3);
        xfer(0, 0, 8'h0C, 2);
        n_busy = 0;
        xfer(0, 0, 8'h01, 2);
        chk("clr_busy_len", (n_busy >= 80 && n_busy <= 81), 1'b1);
        for (int i = 0; i < 80; i++) begin
            rd(i, v);
            chk("clr_cell", v, 8'h20);
        end
        rd(100, v);
        chk("rd_oob", v, 8'h00);

        xfer(0, 0, 8'h93, 2);
        xfer(1, 0, 8'h41, 2);
        xfer(1, 0, 8'h42, 4);
        rd(19, v); chk("cell19", v, 8'h41);
        rd(20, v); chk("cell20", v, 8'h42);
        chk("cur21", cursor_idx, 7'd21);

`ifdef LCD_RX_READ_EN
        xfer(0, 0, 8'h93, 2);
        rd_bus(1, v, oe);
        chk("rd_data19", v, 8'h41);
        chk("rd_oe", oe, 1'b1);
        m_cur = 20;
        chk("rd_adv", cursor_idx, 7'd20);
`endif

        xfer(0, 0, 8'hE7, 2);
        xfer(1, 0, 8'h5A, 2);
        rd(79, v); chk("cell79", v, 8'h5A);
        chk("wrap_fwd", cursor_idx, 7'd0);
        xfer(0, 0, 8'h04, 2);
        xfer(0, 0, 8'h10, 2);
        chk("wrap_back", cursor_idx, 7'd79);

        xfer(0, 0, 8'hB0, 2);
        chk("bad_addr_err", err, 1'b1);
        xfer(0, 0, 8'h02, 1);

        for (int n = 0; n < 150; n++) begin
            k = $urandom_range(0, 9);
            d = 8'($urandom);
            case (k)
                0, 1, 2: xfer(1, 0, d, $urandom_range(2, 4));
                3: begin
                    int idx;
                    idx = $urandom_range(0, 79);
                    xfer(0, 0, 8'h80 | 8'(idx < 40 ? idx : idx + 8'h18), 2);
                end
                4: xfer(0, 0, 8'h80 | d, 2);
                5: xfer(0, 0, 8'h04 | (d & 8'h03), 2);
                6: xfer(0, 0, 8'h08 | (d & 8'h07), 3);
                7: xfer(0, 0, 8'h10 | (d & 8'h2F), 2);
                8: xfer(0, 0, (d[0] ? 8'h40 | (d & 8'h3F) : (d & 8'h03)), 2);
                default: begin
`ifndef LCD_RX_READ_EN
                    if (d[7]) xfer(d[1], 1, d, 2);
                    else
`endif
                    xfer(d[1], 0, d, 1);
                end
            endcase
        end
        for (int i = 0; i < 80; i++) begin
            rd(i, v);
            chk("rand_cell", v, m_mem[i]);
        end

        s0 = n_strobe;
        bus(0, 0, 8'h01, 2);
        bus(1, 0, 8'h55, 2);
`ifdef LCD_RX_READ_EN
        rd_bus(0, v, oe);
        chk("stat_busy", v[7], 1'b1);
`endif
        wait_idle();
        chk("drop_err", err, 1'b1);
        chk("drop_strobe", n_strobe - s0, 1);
        rd(0, v); chk("drop_cell0", v, 8'h20);
        chk("drop_cursor", cursor_idx, 7'd0);

        xfer(0, 0, 8'hE7, 2);
        xfer(1, 0, 8'h77, 2);
        old79 = 8'h77;
        bus(0, 0, 8'h01, 2);
        repeat (8) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", {busy, err}, 2'b00);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        rd(0, v); chk("abort_cell0", v, 8'h20);
        rd(79, v); chk("abort_cell79", v, old79);
        chk("abort_cursor", cursor_idx, 7'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
